// File: rtl/nv_nvdla_mcif_write_eg_pkg.sv
// Shared MCIF write definitions: client encoding, CQ entry layout and bid thread field.
package nv_nvdla_mcif_write_eg_pkg;
   localparam int MCIF_NUM_CLIENT = 5;
   localparam int CQ_PD_W         = 3;
   localparam int PD_ACK_BIT      = 0;
   localparam int PD_LEN_LSB      = 1;
   localparam int PD_LEN_W        = 2;
   localparam int BID_W           = 8;
   localparam int TID_LSB         = 0;
   localparam int TID_W           = 4;

   typedef enum logic [2:0] {
      CLI_BDMA = 3'd0,
      CLI_SDP  = 3'd1,
      CLI_PDP  = 3'd2,
      CLI_CDP  = 3'd3,
      CLI_RBK  = 3'd4
   } client_e;

   function automatic logic [PD_LEN_W-1:0] pd_len(input logic [CQ_PD_W-1:0] pd);
      return pd[PD_LEN_LSB +: PD_LEN_W];
   endfunction

   function automatic logic pd_ack(input logic [CQ_PD_W-1:0] pd);
      return pd[PD_ACK_BIT];
   endfunction

   function automatic logic [TID_W-1:0] bid_tid(input logic [BID_W-1:0] bid);
      return bid[TID_LSB +: TID_W];
   endfunction
endpackage

// File: rtl/nv_nvdla_mcif_write_eg_pipe.sv
// One-entry valid/ready capture register for the AXI B channel.
module nv_nvdla_mcif_write_eg_pipe
   import nv_nvdla_mcif_write_eg_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_vld_i,
   input  logic [TID_W-1:0] in_tid_i,
   output logic             in_rdy_o,
   input  logic             pop_i,
   output logic             p_vld_o,
   output logic [TID_W-1:0] p_tid_o
);
   logic             p_vld_q, p_vld_d;
   logic [TID_W-1:0] p_tid_q, p_tid_d;

   // Ready depends only on the held entry and its pop, never on the incoming valid.
   assign in_rdy_o = !p_vld_q || pop_i;

   always_comb begin
      p_vld_d = p_vld_q;
      p_tid_d = p_tid_q;
      if (in_rdy_o) begin
         p_vld_d = in_vld_i;
         if (in_vld_i) p_tid_d = in_tid_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         p_vld_q <= 1'b0;
         p_tid_q <= '0;
      end else begin
         p_vld_q <= p_vld_d;
         p_tid_q <= p_tid_d;
      end
   end

   assign p_vld_o = p_vld_q;
   assign p_tid_o = p_tid_q;
endmodule

// File: rtl/nv_nvdla_mcif_write_eg.sv
// MCIF write egress: matches B responses to context-queue entries, returns credits and completions.
module nv_nvdla_mcif_write_eg
   import nv_nvdla_mcif_write_eg_pkg::*;
#(
   parameter int NUM_CLIENT = MCIF_NUM_CLIENT
)(
   input  logic               nvdla_core_clk,
   input  logic               nvdla_core_rstn,
   input  logic               noc2mcif_axi_b_bvalid,
   output logic               mcif2noc_axi_b_bready,
   input  logic [BID_W-1:0]   noc2mcif_axi_b_bid,
   input  logic               cq_rd0_pvld,
   input  logic               cq_rd1_pvld,
   input  logic               cq_rd2_pvld,
   input  logic               cq_rd3_pvld,
   input  logic               cq_rd4_pvld,
   output logic               cq_rd0_prdy,
   output logic               cq_rd1_prdy,
   output logic               cq_rd2_prdy,
   output logic               cq_rd3_prdy,
   output logic               cq_rd4_prdy,
   input  logic [CQ_PD_W-1:0] cq_rd0_pd,
   input  logic [CQ_PD_W-1:0] cq_rd1_pd,
   input  logic [CQ_PD_W-1:0] cq_rd2_pd,
   input  logic [CQ_PD_W-1:0] cq_rd3_pd,
   input  logic [CQ_PD_W-1:0] cq_rd4_pd,
   output logic               mcif2bdma_wr_rsp_complete,
   output logic               mcif2sdp_wr_rsp_complete,
   output logic               mcif2pdp_wr_rsp_complete,
   output logic               mcif2cdp_wr_rsp_complete,
   output logic               mcif2rbk_wr_rsp_complete,
   output logic               eg2ig_axi_vld,
   output logic [PD_LEN_W-1:0] eg2ig_axi_len
);
   logic [NUM_CLIENT-1:0]              cq_pvld, cq_prdy;
   logic [NUM_CLIENT-1:0][CQ_PD_W-1:0] cq_pd;
   logic                               p_vld, p_hit, p_pop, cq_hs, sel_pvld;
   logic [TID_W-1:0]                   p_tid;
   logic [CQ_PD_W-1:0]                 sel_pd;
   logic                               vld_q, vld_d;
   logic [PD_LEN_W-1:0]                len_q, len_d;
   logic [NUM_CLIENT-1:0]              cmpl_q, cmpl_d;
   logic                               unused_bid_hi;

   assign cq_pvld = {cq_rd4_pvld, cq_rd3_pvld, cq_rd2_pvld, cq_rd1_pvld, cq_rd0_pvld};
   assign cq_pd   = {cq_rd4_pd, cq_rd3_pd, cq_rd2_pd, cq_rd1_pd, cq_rd0_pd};
   assign unused_bid_hi = ^noc2mcif_axi_b_bid[BID_W-1:TID_LSB+TID_W];

   nv_nvdla_mcif_write_eg_pipe u_pipe (
      .clk_i    (nvdla_core_clk),
      .rst_n_i  (nvdla_core_rstn),
      .in_vld_i (noc2mcif_axi_b_bvalid),
      .in_tid_i (bid_tid(noc2mcif_axi_b_bid)),
      .in_rdy_o (mcif2noc_axi_b_bready),
      .pop_i    (p_pop),
      .p_vld_o  (p_vld),
      .p_tid_o  (p_tid)
   );

   for (genvar g = 0; g < NUM_CLIENT; g++) begin : g_prdy
      assign cq_prdy[g] = p_vld && (p_tid == TID_W'(g));
   end

   always_comb begin
      sel_pvld = 1'b0;
      sel_pd   = '0;
      for (int i = 0; i < NUM_CLIENT; i++) begin
         if (cq_prdy[i]) begin
            sel_pvld = cq_pvld[i];
            sel_pd   = cq_pd[i];
         end
      end
   end

   // Out-of-range thread ids are popped straight away and produce nothing.
   assign p_hit = p_tid < TID_W'(NUM_CLIENT);
   assign p_pop = p_vld && (!p_hit || sel_pvld);
   assign cq_hs = p_vld && p_hit && sel_pvld;

   always_comb begin
      vld_d  = cq_hs;
      len_d  = cq_hs ? pd_len(sel_pd) : len_q;
      cmpl_d = pd_ack(sel_pd) ? (cq_pvld & cq_prdy) : '0;
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         vld_q  <= 1'b0;
         len_q  <= '0;
         cmpl_q <= '0;
      end else begin
         vld_q  <= vld_d;
         len_q  <= len_d;
         cmpl_q <= cmpl_d;
      end
   end

   assign cq_rd0_prdy = cq_prdy[0];
   assign cq_rd1_prdy = cq_prdy[1];
   assign cq_rd2_prdy = cq_prdy[2];
   assign cq_rd3_prdy = cq_prdy[3];
   assign cq_rd4_prdy = cq_prdy[4];

   assign mcif2bdma_wr_rsp_complete = cmpl_q[CLI_BDMA];
   assign mcif2sdp_wr_rsp_complete  = cmpl_q[CLI_SDP];
   assign mcif2pdp_wr_rsp_complete  = cmpl_q[CLI_PDP];
   assign mcif2cdp_wr_rsp_complete  = cmpl_q[CLI_CDP];
   assign mcif2rbk_wr_rsp_complete  = cmpl_q[CLI_RBK];
   assign eg2ig_axi_vld             = vld_q;
   assign eg2ig_axi_len             = len_q;
endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg.sv
// Bench for the MCIF write egress: directed table, corner sequences, random vs. order-based model.
module tb_nv_nvdla_mcif_write_eg;
   logic       clk = 1'b0;
   logic       rstn;
   logic       bvalid, bready;
   logic [7:0] bid;
   logic [4:0] pvld, prdy, cmpl;
   logic [2:0] pd [5];
   logic       vld;
   logic [1:0] len;

   always #5 clk = ~clk;

   nv_nvdla_mcif_write_eg dut (
      .nvdla_core_clk            (clk),
      .nvdla_core_rstn           (rstn),
      .noc2mcif_axi_b_bvalid     (bvalid),
      .mcif2noc_axi_b_bready     (bready),
      .noc2mcif_axi_b_bid        (bid),
      .cq_rd0_pvld               (pvld[0]),
      .cq_rd1_pvld               (pvld[1]),
      .cq_rd2_pvld               (pvld[2]),
      .cq_rd3_pvld               (pvld[3]),
      .cq_rd4_pvld               (pvld[4]),
      .cq_rd0_prdy               (prdy[0]),
      .cq_rd1_prdy               (prdy[1]),
      .cq_rd2_prdy               (prdy[2]),
      .cq_rd3_prdy               (prdy[3]),
      .cq_rd4_prdy               (prdy[4]),
      .cq_rd0_pd                 (pd[0]),
      .cq_rd1_pd                 (pd[1]),
      .cq_rd2_pd                 (pd[2]),
      .cq_rd3_pd                 (pd[3]),
      .cq_rd4_pd                 (pd[4]),
      .mcif2bdma_wr_rsp_complete (cmpl[0]),
      .mcif2sdp_wr_rsp_complete  (cmpl[1]),
      .mcif2pdp_wr_rsp_complete  (cmpl[2]),
      .mcif2cdp_wr_rsp_complete  (cmpl[3]),
      .mcif2rbk_wr_rsp_complete  (cmpl[4]),
      .eg2ig_axi_vld             (vld),
      .eg2ig_axi_len             (len)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        bv;
      logic [7:0]  bid;
      logic [4:0]  pv;
      logic [14:0] pd;
      logic        e_brdy;
      logic [4:0]  e_prdy;
      logic        e_vld;
      logic [1:0]  e_len;
      logic [4:0]  e_cmpl;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [14:0] pds(input logic [2:0] p0, p1, p2, p3, p4);
      return {p4, p3, p2, p1, p0};
   endfunction

   task automatic add(input logic bv, input logic [7:0] b, input logic [4:0] pv, input logic [14:0] p,
                      input logic eb, input logic [4:0] ep, input logic ev, input logic [1:0] el,
                      input logic [4:0] ec);
      vec_t v;
      v.bv = bv; v.bid = b; v.pv = pv; v.pd = p;
      v.e_brdy = eb; v.e_prdy = ep; v.e_vld = ev; v.e_len = el; v.e_cmpl = ec;
      tbl.push_back(v);
   endtask

   task automatic set_pd(input logic [14:0] p);
      for (int i = 0; i < 5; i++) pd[i] = p[3*i +: 3];
   endtask

   // Random-phase model: per-thread CQ contents and the ordered list of expected pulses.
   typedef struct packed { logic [1:0] len; logic ack; logic [2:0] tid; } ev_t;
   ev_t        expq[$];
   logic [2:0] cq_all [5][$];
   int         rd_idx [5];
   int         exp_idx[5];
   logic       cur_bv;
   logic [7:0] cur_bid;

   task automatic rnd_cycle(input bit allow_new);
      int   t;
      ev_t  e;
      @(negedge clk);
      if (allow_new && !cur_bv && $urandom_range(0, 9) < 6) begin
         t = $urandom_range(0, 6);
         cur_bid = {4'($urandom), 4'(t)};
         cur_bv = 1'b1;
         if (t < 5) cq_all[t].push_back(3'($urandom));
      end
      bvalid = cur_bv;
      bid = cur_bid;
      for (int i = 0; i < 5; i++) begin
         if (rd_idx[i] < cq_all[i].size()) begin
            pvld[i] = (!allow_new) || ($urandom_range(0, 3) != 0);
            pd[i] = cq_all[i][rd_idx[i]];
         end else begin
            pvld[i] = 1'b0;
            pd[i] = 3'($urandom);
         end
      end
      #2;
      chk("rnd_prdy_onehot", 32'($countones(prdy) <= 1), 32'd1);
      if (vld) begin
         if (expq.size() == 0) begin
            chk("rnd_unexpected_credit", 32'(vld), 32'd0);
         end else begin
            e = expq.pop_front();
            chk("rnd_len", 32'(len), 32'(e.len));
            chk("rnd_cmpl", 32'(cmpl), e.ack ? (32'd1 << e.tid) : 32'd0);
         end
      end else begin
         chk("rnd_idle_cmpl", 32'(cmpl), 32'd0);
      end
      if (bvalid && bready) begin
         t = int'(bid[3:0]);
         if (t < 5) begin
            e.tid = 3'(t);
            e.len = cq_all[t][exp_idx[t]][2:1];
            e.ack = cq_all[t][exp_idx[t]][0];
            exp_idx[t]++;
            expq.push_back(e);
         end
         cur_bv = 1'b0;
      end
      for (int i = 0; i < 5; i++) if (pvld[i] && prdy[i]) rd_idx[i]++;
   endtask

   task automatic drive(input logic bv, input logic [7:0] b, input logic [4:0] pv);
      @(negedge clk);
      bvalid = bv; bid = b; pvld = pv;
      #2;
   endtask

   initial begin
      logic [14:0] P;
      int hs, ncmpl;
      rstn = 1'b0; bvalid = 1'b0; bid = '0; pvld = '0; set_pd('0);
      cur_bv = 1'b0; cur_bid = '0;
      for (int i = 0; i < 5; i++) begin rd_idx[i] = 0; exp_idx[i] = 0; end
      repeat (2) @(negedge clk);
      #2;
      chk("rst_bready", 32'(bready), 32'd1);
      chk("rst_prdy", 32'(prdy), 32'd0);
      chk("rst_vld", 32'(vld), 32'd0);
      chk("rst_len", 32'(len), 32'd0);
      chk("rst_cmpl", 32'(cmpl), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // single ack on pdp, len 1
      P = pds(3'b000, 3'b000, 3'b011, 3'b000, 3'b000);
      add(1, 8'h02, 5'b00100, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b00100, P, 1, 5'b00100, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b00000, P, 1, 5'b00000, 1, 2'd1, 5'b00100);
      add(0, 8'h00, 5'b00000, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      // rbk without ack: credit only
      P = pds(3'b000, 3'b000, 3'b000, 3'b000, 3'b110);
      add(1, 8'h04, 5'b10000, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b10000, P, 1, 5'b10000, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b00000, P, 1, 5'b00000, 1, 2'd3, 5'b00000);
      // invalid id dropped, next bid 0 processed
      P = pds(3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
      add(1, 8'h07, 5'b11111, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      add(1, 8'h00, 5'b11111, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b11111, P, 1, 5'b00001, 0, 2'd0, 5'b00000);
      add(0, 8'h00, 5'b11111, P, 1, 5'b00000, 1, 2'd0, 5'b00001);
      // back-to-back 0,1,3,0
      P = pds(3'b001, 3'b011, 3'b000, 3'b101, 3'b000);
      add(1, 8'h00, 5'b11111, P, 1, 5'b00000, 0, 2'd0, 5'b00000);
      add(1, 8'h01, 5'b11111, P, 1, 5'b00001, 0, 2'd0, 5'b00000);
      add(1, 8'h03, 5'b11111, P, 1, 5'b00010, 1, 2'd0, 5'b00001);
      add(1, 8'h00, 5'b11111, P, 1, 5'b01000, 1, 2'd1, 5'b00010);
      add(0, 8'h00, 5'b11111, P, 1, 5'b00001, 1, 2'd2, 5'b01000);
      add(0, 8'h00, 5'b11111, P, 1, 5'b00000, 1, 2'd0, 5'b00001);
      add(0, 8'h00, 5'b11111, P, 1, 5'b00000, 0, 2'd0, 5'b00000);

      for (int r = 0; r < tbl.size(); r++) begin
         set_pd(tbl[r].pd);
         drive(tbl[r].bv, tbl[r].bid, tbl[r].pv);
         chk($sformatf("tbl%0d_bready", r), 32'(bready), 32'(tbl[r].e_brdy));
         chk($sformatf("tbl%0d_prdy", r), 32'(prdy), 32'(tbl[r].e_prdy));
         chk($sformatf("tbl%0d_vld", r), 32'(vld), 32'(tbl[r].e_vld));
         chk($sformatf("tbl%0d_cmpl", r), 32'(cmpl), 32'(tbl[r].e_cmpl));
         if (tbl[r].e_vld) chk($sformatf("tbl%0d_len", r), 32'(len), 32'(tbl[r].e_len));
      end

      // CQ empty stall on sdp for 5 cycles
      set_pd(pds(3'b000, 3'b001, 3'b000, 3'b000, 3'b000));
      drive(1, 8'h01, 5'b00000);
      chk("stall_accept", 32'(bready), 32'd1);
      hs = 0; ncmpl = 0;
      for (int k = 0; k < 5; k++) begin
         drive(0, 8'h00, 5'b00000);
         chk("stall_bready", 32'(bready), 32'd0);
         chk("stall_prdy", 32'(prdy), 32'b00010);
         chk("stall_vld", 32'(vld), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 8'h00, 5'b00010);
         if (pvld[1] && prdy[1]) hs++;
         if (cmpl[1]) ncmpl++;
         if (k == 0) chk("stall_release_bready", 32'(bready), 32'd1);
         if (k == 1) chk("stall_cmpl_timing", 32'(cmpl), 32'b00010);
      end
      chk("stall_handshakes", 32'(hs), 32'd1);
      chk("stall_completions", 32'(ncmpl), 32'd1);

      // reset while a response is held against an empty CQ
      set_pd(pds(3'b000, 3'b000, 3'b000, 3'b001, 3'b000));
      drive(1, 8'h03, 5'b00000);
      drive(0, 8'h00, 5'b00000);
      chk("prerst_stall", 32'(bready), 32'd0);
      rstn = 1'b0;
      #1;
      chk("midrst_bready", 32'(bready), 32'd1);
      chk("midrst_prdy", 32'(prdy), 32'd0);
      drive(0, 8'h00, 5'b00000);
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(0, 8'h00, 5'b01000);
         chk("postrst_bready", 32'(bready), 32'd1);
         chk("postrst_prdy", 32'(prdy), 32'd0);
         chk("postrst_vld", 32'(vld), 32'd0);
         chk("postrst_cmpl", 32'(cmpl), 32'd0);
      end
      pvld = '0;

      // random traffic against the ordered model
      for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 60; c++) rnd_cycle(1'b0);
      chk("drain_pending_b", 32'(cur_bv), 32'd0);
      chk("drain_expq_empty", 32'(expq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
